// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns byte-addressed MIPS loads/stores into word
// accesses on a one-cycle-latency synchronous data_mem, with RMW for sub-word stores.
module mem_access_unit #(
  parameter int DATA = 32,
  parameter int ADDR = 15
) (
  input  logic            clka,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [31:0]     req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_rdata,
  output logic            st_done,
  output logic            misalign,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_MERGE} state_t;

  state_t          state;
  logic            we_p0;
  logic            sgn_p0;
  logic [1:0]      size_p0;
  logic [1:0]      off_p0;
  logic [ADDR-1:0] idx_p0;
  logic [DATA-1:0] wdata_p0;

  logic            accept;
  logic            aligned;
  logic            unused_addr_hi;

  function automatic logic req_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Big-endian lane select: offset 0 is the most significant byte/half.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   return sgn ? 32'(b) : {24'd0, b};
      2'b01:   return sgn ? 32'(h) : {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (off)
        2'b00:   m[31:24] = wdata[7:0];
        2'b01:   m[23:16] = wdata[7:0];
        2'b10:   m[15:8]  = wdata[7:0];
        default: m[7:0]   = wdata[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) m[15:0]  = wdata[15:0];
      else        m[31:16] = wdata[15:0];
    end else begin
      m = wdata;
    end
    return m;
  endfunction

  assign req_ready      = (state == IDLE);
  assign accept         = req_valid && req_ready;
  assign aligned        = req_aligned(req_size, req_addr[1:0]);
  assign unused_addr_hi = ^req_addr[31:ADDR+2];

  // Memory port: live request while idle, latched request while sequencing.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = idx_p0;
    mem_din  = store_merge(mem_dout, wdata_p0, off_p0, size_p0);
    if (state == IDLE) begin
      mem_addr = req_addr[ADDR+1:2];
      mem_din  = req_wdata;
      mem_we   = accept && req_we && (req_size == 2'b10) && aligned;
    end else if (state == ST_MERGE) begin
      mem_we = we_p0;
    end
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
      rsp_rdata <= '0;
      we_p0     <= 1'b0;
      sgn_p0    <= 1'b0;
      size_p0   <= 2'b00;
      off_p0    <= 2'b00;
      idx_p0    <= '0;
      wdata_p0  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_p0    <= req_we;
            sgn_p0   <= req_signed;
            size_p0  <= req_size;
            off_p0   <= req_addr[1:0];
            idx_p0   <= req_addr[ADDR+1:2];
            wdata_p0 <= req_wdata;
            if (!aligned)                 misalign <= 1'b1;
            else if (!req_we)             state    <= LD_WAIT;
            else if (req_size == 2'b10)   st_done  <= 1'b1;
            else                          state    <= ST_MERGE;
          end
        end
        LD_WAIT: begin
          rsp_rdata <= load_extract(mem_dout, off_p0, size_p0, sgn_p0);
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        ST_MERGE: begin
          st_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-array reference
// memory, with a behavioural synchronous data_mem attached to the memory port.
module tb_mem_access_unit;
  localparam int ADDR  = 15;
  localparam int NBYTE = 1 << (ADDR + 2);

  logic            clka = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [1:0]      req_size = 2'b10;
  logic            req_signed = 1'b0;
  logic [31:0]     req_addr = '0;
  logic [31:0]     req_wdata = '0;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            st_done;
  logic            misalign;
  logic            mem_we;
  logic [ADDR-1:0] mem_addr;
  logic [31:0]     mem_din;
  logic [31:0]     mem_dout;

  logic [31:0] dmem  [0:(1<<ADDR)-1];
  logic [7:0]  ref_b [0:NBYTE-1];
  int checks = 0;
  int failures = 0;

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (mem_we) dmem[mem_addr] <= mem_din;
    mem_dout <= dmem[mem_addr];
  end

  mem_access_unit #(.DATA(32), .ADDR(ADDR)) dut (
    .clka(clka), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .st_done(st_done), .misalign(misalign),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic bit ref_aligned(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (addr % 2) == 0;
      2'd2:    return (addr % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int unsigned a;
    longint v;
    a = addr % NBYTE;
    if (size == 2'd0) begin
      v = ref_b[a];
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = ref_b[a] * 256 + ref_b[a+1];
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = ((longint'(ref_b[a]) * 256 + ref_b[a+1]) * 256 + ref_b[a+2]) * 256 + ref_b[a+3];
    end
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned a, n;
    a = addr % NBYTE;
    n = 1 << size;
    for (int i = 0; i < n; i++) ref_b[a+i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  // Issues one request and observes the following five cycles; no judging here.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat_rsp, output int lat_st, output int lat_mis,
                       output int npulse, output int we_cnt, output int ready_low,
                       output logic [31:0] rdata);
    lat_rsp = -1; lat_st = -1; lat_mis = -1; npulse = 0; ready_low = 0; rdata = 'x;
    @(negedge clka);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    we_cnt = mem_we ? 1 : 0;
    @(negedge clka);
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (rsp_valid) begin if (lat_rsp < 0) lat_rsp = k; rdata = rsp_rdata; npulse++; end
      if (st_done)  begin if (lat_st < 0)  lat_st = k;  npulse++; end
      if (misalign) begin if (lat_mis < 0) lat_mis = k; npulse++; end
      if (mem_we) we_cnt++;
      if (!req_ready) ready_low++;
      @(negedge clka);
    end
    if (we && ref_aligned(size, addr)) ref_store(size, addr, wdata);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clka); #1;
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      checks++; if ({rsp_valid, st_done, misalign} !== 3'b000) begin
        failures++; $display("FAIL rst_pulses got=%b exp=000", {rsp_valid, st_done, misalign}); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    end
    @(negedge clka);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clka); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (dmem[16] !== 32'h0) begin failures++; $display("FAIL rst_nowrite got=%h exp=0", dmem[16]); end
  endtask

  task automatic test_word();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd;
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, lr, ls, lm, np, wc, rl, rd);
    checks++; if (ls !== 1) begin failures++; $display("FAIL sw_lat got=%0d exp=1", ls); end
    checks++; if (wc !== 1) begin failures++; $display("FAIL sw_we got=%0d exp=1", wc); end
    checks++; if (np !== 1) begin failures++; $display("FAIL sw_pulses got=%0d exp=1", np); end
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (lr !== 2) begin failures++; $display("FAIL lw_lat got=%0d exp=2", lr); end
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL lw_data got=%h exp=11223344", rd); end
    checks++; if (wc !== 0) begin failures++; $display("FAIL lw_we got=%0d exp=0", wc); end
  endtask

  task automatic test_subword_load();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd;
    issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'h00000022) begin failures++; $display("FAIL lb41 got=%h exp=00000022", rd); end
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'h00003344) begin failures++; $display("FAIL lhu42 got=%h exp=00003344", rd); end
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h80000000, lr, ls, lm, np, wc, rl, rd);
    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'hFFFF8000) begin failures++; $display("FAIL lh40 got=%h exp=FFFF8000", rd); end
    checks++; if (lr !== 2) begin failures++; $display("FAIL lh_lat got=%0d exp=2", lr); end
  endtask

  task automatic test_sb();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd;
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, lr, ls, lm, np, wc, rl, rd);
    issue(1'b1, 2'd0, 1'b0, 32'h43, 32'h00000080, lr, ls, lm, np, wc, rl, rd);
    checks++; if (ls !== 2) begin failures++; $display("FAIL sb_lat got=%0d exp=2", ls); end
    checks++; if (rl !== 1) begin failures++; $display("FAIL sb_ready_low got=%0d exp=1", rl); end
    checks++; if (wc !== 1) begin failures++; $display("FAIL sb_we got=%0d exp=1", wc); end
    checks++; if (dmem[16] !== 32'h11223380) begin failures++; $display("FAIL sb_mem got=%h exp=11223380", dmem[16]); end
    issue(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb43 got=%h exp=FFFFFF80", rd); end
    issue(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu43 got=%h exp=00000080", rd); end
  endtask

  task automatic test_misalign();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd;
    issue(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, lr, ls, lm, np, wc, rl, rd);
    checks++; if (lm !== 1) begin failures++; $display("FAIL sh41_mis got=%0d exp=1", lm); end
    checks++; if (wc !== 0) begin failures++; $display("FAIL sh41_we got=%0d exp=0", wc); end
    checks++; if (np !== 1) begin failures++; $display("FAIL sh41_pulses got=%0d exp=1", np); end
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (lm !== 1) begin failures++; $display("FAIL lw42_mis got=%0d exp=1", lm); end
    checks++; if (lr !== -1) begin failures++; $display("FAIL lw42_rsp got=%0d exp=-1", lr); end
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'h11223380) begin failures++; $display("FAIL lw40_after got=%h exp=11223380", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    @(negedge clka);
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h80; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clka);
    ref_store(2'd2, 32'h80, 32'hCAFEF00D);
    req_we = 1'b0;
    #1;
    checks++; if ({st_done, req_ready} !== 2'b11) begin
      failures++; $display("FAIL b2b_st_ready got=%b exp=11", {st_done, req_ready}); end
    @(negedge clka);
    req_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", req_ready); end
    @(negedge clka);
    req_size = 2'd0; req_addr = 32'h83; req_valid = 1'b1;
    #1;
    exp = ref_load(2'd2, 1'b0, 32'h80);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      failures++; $display("FAIL b2b_lw got=%b/%h exp=1/%h", rsp_valid, rsp_rdata, exp); end
    @(negedge clka);
    req_valid = 1'b0;
    @(negedge clka); #1;
    exp = ref_load(2'd0, 1'b0, 32'h83);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      failures++; $display("FAIL b2b_lbu got=%b/%h exp=1/%h", rsp_valid, rsp_rdata, exp); end
  endtask

  task automatic test_reset_mid_rmw();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd;
    issue(1'b1, 2'd2, 1'b0, 32'h44, 32'h55667788, lr, ls, lm, np, wc, rl, rd);
    @(negedge clka);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h44; req_wdata = 32'hAA; req_valid = 1'b1;
    @(negedge clka);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", mem_we); end
    @(negedge clka);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({st_done, rsp_valid} !== 2'b00) begin
        failures++; $display("FAIL rstmid_pulse got=%b exp=00", {st_done, rsp_valid}); end
      @(negedge clka);
    end
    checks++; if (dmem[17] !== 32'h55667788) begin failures++; $display("FAIL rstmid_mem got=%h exp=55667788", dmem[17]); end
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, lr, ls, lm, np, wc, rl, rd);
    checks++; if (rd !== 32'h55667788) begin failures++; $display("FAIL rstmid_lw got=%h exp=55667788", rd); end
  endtask

  task automatic test_random();
    int lr, ls, lm, np, wc, rl; logic [31:0] rd, exp, addr, wdata, wexp;
    logic we, sgn; logic [1:0] size;
    for (int n = 0; n < 200; n++) begin
      addr = 32'h100 + $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFE_0000);
      we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); wdata = $urandom;
      exp = ref_load(size, sgn, addr);
      issue(we, size, sgn, addr, wdata, lr, ls, lm, np, wc, rl, rd);
      checks++; if (np !== 1) begin failures++; $display("FAIL rnd_pulses n=%0d got=%0d exp=1", n, np); end
      if (!ref_aligned(size, addr)) begin
        checks++; if (lm !== 1 || wc !== 0) begin
          failures++; $display("FAIL rnd_mis n=%0d got=%0d/%0d exp=1/0", n, lm, wc); end
      end else if (!we) begin
        checks++; if (lr !== 2 || rd !== exp) begin
          failures++; $display("FAIL rnd_load n=%0d a=%h sz=%0d got=%0d/%h exp=2/%h", n, addr, size, lr, rd, exp); end
      end else begin
        wexp = ref_load(2'd2, 1'b0, addr & 32'hFFFF_FFFC);
        checks++; if (ls !== ((size == 2'd2) ? 1 : 2) || wc !== 1) begin
          failures++; $display("FAIL rnd_store_lat n=%0d got=%0d/%0d", n, ls, wc); end
        checks++; if (dmem[(addr % NBYTE) / 4] !== wexp) begin
          failures++; $display("FAIL rnd_store_mem n=%0d a=%h got=%h exp=%h", n, addr, dmem[(addr % NBYTE) / 4], wexp); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR); i++) dmem[i] = 32'h0;
    for (int i = 0; i < NBYTE; i++) ref_b[i] = 8'h0;
    test_reset();
    test_word();
    test_subword_load();
    test_sb();
    test_misalign();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the MIPS pipeline; sits directly upstream of data_mem and is its only driver.
- Converts byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests into word accesses on data_mem's synchronous-read, one-cycle-latency port.
- Sub-word stores use a read-modify-write sequence.
- Loads are returned aligned and sign/zero-extended. Misaligned accesses are flagged and never touch memory.

Parameters:
DATA, 32, data width (fixed 32; sub-word lanes assume 32)
ADDR, 15, data_mem word-address width; word index = req_addr[ADDR+1:2]

Ports:
clka  in  1  clock, shared with data_mem
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
req_signed  in  1  sign-extend sub-word loads
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle pulse, rsp_rdata valid
rsp_rdata  out  32  extended load result
st_done  out  1  one-cycle pulse, store committed
misalign  out  1  one-cycle pulse, request rejected
mem_we  out  1  to data_mem wea
mem_addr  out  ADDR  to data_mem addra
mem_din  out  32  to data_mem dina
mem_dout  in  32  from data_mem douta

Behaviour:
- One clock (clka), synchronous active-high reset (rst). All state updates on posedge clka.
- Reset values:
  - state = IDLE
  - rsp_valid, st_done, misalign = 0
  - rsp_rdata = 0
  - latched request registers = 0
- mem_we is forced 0 combinationally while rst is high.
- Byte order is big-endian:
  - byte offset 0 = bits 31:24, offset 3 = bits 7:0
  - half offset 0 = bits 31:16, offset 2 = bits 15:0
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=00. Upper address bits above ADDR+1 are ignored (wrap modulo memory size).
- Accept = req_valid && req_ready. On accept, the unit latches we, size, signed, byte offset, word index and wdata.
- Memory outputs in IDLE are combinational from the live request; in other states they come from the latched request.
- States:
  - IDLE:
    - mem_addr = live word index; mem_din = req_wdata.
    - mem_we = accept && word store && aligned.
    - On accept:
      - misaligned -> misalign=1 next cycle; stay IDLE; mem_we=0.
      - word store -> written at this edge; st_done=1 next cycle; stay IDLE.
      - load -> LD_WAIT.
      - sub-word store -> ST_MERGE (this cycle issues a read; mem_we=0).
  - LD_WAIT:
    - mem_dout is valid.
    - Select lane by offset and size, extend by req_signed (word ignores it).
    - Register into rsp_rdata; rsp_valid=1 next cycle; -> IDLE.
  - ST_MERGE:
    - mem_we=1; mem_addr = latched index.
    - mem_din = mem_dout with the addressed lane replaced by the low 8/16 bits of latched wdata; other lanes unchanged.
    - st_done=1 next cycle; -> IDLE.
- Latency, counted from the accept edge E0:
  - load: rsp_valid high in the cycle after E1 (2 cycles)
  - word store: st_done in the cycle after E0
  - sub-word store: st_done in the cycle after E1
- req_ready is low in LD_WAIT and ST_MERGE; the pipeline stalls on !req_ready.
- Back-to-back requests are allowed: a new request can be accepted in the same cycle that a previous rsp_valid/st_done pulse is high.
- Reset mid-operation: an in-flight RMW or load is abandoned; no write is issued and no pulse is produced.
- Pulses are exactly one cycle wide. rsp_rdata holds its value until the next load completes.

Test Plan:
- Reset: assert rst 2 cycles with req_valid=1 -> mem_we never 1, all pulses 0, req_ready=1 after release.
- sw 0x11223344 @0x40, then lw @0x40 -> st_done the cycle after accept; rsp_valid 2 cycles after accept with rsp_rdata=0x11223344.
- lb signed @0x41 -> 0x00000022; lhu @0x42 -> 0x00003344; lh signed @0x40 after sw 0x80000000 -> 0xFFFF8000.
- sb 0x80 @0x43 over 0x11223344 -> one read cycle then write of 0x11223380, req_ready low 1 cycle; then lb signed @0x43 -> 0xFFFFFF80, lbu -> 0x00000080.
- sh @0x41 and lw @0x42 -> misalign pulse each, no mem_we; a subsequent lw @0x40 returns unchanged data.
- Assert rst during ST_MERGE of sb 0xAA @0x44 -> no write; word @0x44 keeps its prior value; no st_done.
